// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Memory-access stage for the single-cycle RISC-V core. Latches a
//             load/store request, drives a req/ack data bus with byte enables,
//             stalls the core until completion or timeout, and returns
//             lane-shifted, sign/zero-extended load data.
//  Options  : MISALIGN_TRAP_EN - adds the 'misalign' output and traps
//             misaligned half/word accesses without touching memory.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Load,
  input  logic [1:0]        Store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  // Load / store function codes from the decoder
  localparam logic [2:0] c_LD_LB  = 3'b000;
  localparam logic [2:0] c_LD_LH  = 3'b001;
  localparam logic [2:0] c_LD_LW  = 3'b010;
  localparam logic [2:0] c_LD_LBU = 3'b011;
  localparam logic [2:0] c_LD_LHU = 3'b100;
  localparam logic [1:0] c_ST_SB  = 2'b00;
  localparam logic [1:0] c_ST_SH  = 2'b01;
  localparam logic [1:0] c_ST_SW  = 2'b10;

  // Last BUSY cycle index before the access is abandoned
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_ld;      // latched load code for result formatting
  logic [1:0]  r_lo;      // latched addr[1:0] for lane selection

  logic        w_access;
  logic        w_legal;
  logic        w_misalign;
  logic        w_start;
  logic        w_go_busy;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Request decode: a store takes priority when both strobes are high
  always_comb begin
    w_access = MemRead | MemWrite;
    if (MemWrite) begin
      w_legal = (Store != 2'b11);
    end else begin
      w_legal = (Load <= c_LD_LHU);
    end
    w_start   = (r_state == S_IDLE) && w_access;
    w_go_busy = w_start && w_legal && !w_misalign;
  end

`ifdef MISALIGN_TRAP_EN
  // Halves need addr[0]=0, words need addr[1:0]=00
  always_comb begin
    w_misalign = 1'b0;
    if (MemWrite) begin
      if (Store == c_ST_SH) w_misalign = addr[0];
      if (Store == c_ST_SW) w_misalign = (addr[1:0] != 2'b00);
    end else begin
      if ((Load == c_LD_LH) || (Load == c_LD_LHU)) w_misalign = addr[0];
      if (Load == c_LD_LW) w_misalign = (addr[1:0] != 2'b00);
    end
  end

  assign misalign = reset && w_start && w_legal && w_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  // Byte enables and lane-replicated store data for the incoming request
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata;
    if (MemWrite) begin
      case (Store)
        c_ST_SB: begin
          w_be    = 4'b0001 << addr[1:0];
          w_wdata = {4{wdata[7:0]}};
        end
        c_ST_SH: begin
          w_be    = addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = wdata;
        end
      endcase
    end
  end

  // Extract the addressed lane of the returned word and extend it
  always_comb begin
    case (r_lo)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_ld)
      c_LD_LB:  w_load = {{24{w_byte[7]}}, w_byte};
      c_LD_LH:  w_load = {{16{w_half[15]}}, w_half};
      c_LD_LW:  w_load = dmem_rdata;
      c_LD_LBU: w_load = {24'd0, w_byte};
      c_LD_LHU: w_load = {16'd0, w_half};
      default:  w_load = 32'd0;
    endcase
  end

  // Core handshake and abort detection
  always_comb begin
    w_timeout = (r_state == S_BUSY) && !dmem_ack && (r_cnt == c_TO_LAST);
    stall     = reset && (w_start || (r_state == S_BUSY));
    bus_err   = w_timeout;
  end

  // Access sequencer: IDLE -> BUSY -> DONE, or IDLE -> DONE for rejected requests
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 16'd0;
      r_ld       <= 3'd0;
      r_lo       <= 2'd0;
      rdata      <= 32'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go_busy) begin
            dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            dmem_be    <= w_be;
            dmem_wdata <= w_wdata;
            dmem_we    <= MemWrite;
            dmem_req   <= 1'b1;
            r_ld       <= Load;
            r_lo       <= addr[1:0];
            r_cnt      <= 16'd0;
            r_state    <= S_BUSY;
          end else if (w_start) begin
            rdata   <= 32'd0;
            r_state <= S_DONE;
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            if (!dmem_we) begin
              rdata <= w_load;
            end
            dmem_req <= 1'b0;
            r_cnt    <= 16'd0;
            r_state  <= S_DONE;
          end else if (w_timeout) begin
            rdata    <= 32'd0;
            dmem_req <= 1'b0;
            r_cnt    <= 16'd0;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the main decoder in the single-cycle RISC-V core.
- Consumes the decoder's Load[2:0], Store[1:0], MemWrite and ResultSrc-derived MemRead, plus the ALU address and rs2 data.
- Drives a req/ack data-memory bus with byte enables and stalls the core until the access completes.
- Returns load data lane-shifted and sign- or zero-extended for the result mux.

Parameters:
TIMEOUT_CYCLES, 255, max BUSY cycles waiting for dmem_ack before abort (1..65535)
ADDR_W, 32, byte address width

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
MemRead  input  1  load in current instruction (ResultSrc==01)
MemWrite  input  1  store in current instruction
Load  input  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu; others illegal
Store  input  2  00 sb, 01 sh, 10 sw; 11 illegal
addr  input  ADDR_W  byte address from ALU
wdata  input  32  store data (rs2)
rdata  output  32  formatted load result, valid in DONE
stall  output  1  freeze PC/pipeline while high
bus_err  output  1  one-cycle pulse on timeout abort
dmem_req  output  1  bus request, held until ack
dmem_we  output  1  1 = write
dmem_addr  output  ADDR_W  word-aligned address (addr[1:0]=00)
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_ack  input  1  bus completion, single-cycle
dmem_rdata  input  32  read word, valid with ack

Behaviour:
- Reset (reset low, async): state IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, rdata=0, bus_err=0, timeout counter=0. stall=0 while reset is low.
- Access request = MemRead|MemWrite. If both are high, the store wins.
- FSM states:
  - IDLE: on access, latch dmem_addr, be, wdata, we, Load code and addr[1:0], then go BUSY. stall=1 combinationally in the request cycle.
  - BUSY: dmem_req=1, stall=1, counter increments. On dmem_ack: format dmem_rdata into rdata (writes leave rdata unchanged), clear counter, go DONE. If counter reaches TIMEOUT_CYCLES-1 with no ack: rdata=0, bus_err=1 for one cycle, drop req, go DONE.
  - DONE: stall=0, dmem_req=0, rdata holds. Core advances on this edge. Next state is always IDLE.
- Latency: zero-wait memory (ack in first BUSY cycle) = 3 cycles (IDLE, BUSY, DONE). Each wait state adds 1.
- dmem_ack outside BUSY is ignored. Inputs change in BUSY are ignored because the request is latched.
- Byte enables:
  - sb: 0001 << addr[1:0].
  - sh: 0011 << (2*addr[1]).
  - sw: 1111.
  - Loads: dmem_be=1111 (full-word read).
- Store data lanes: sb replicates wdata[7:0] x4; sh replicates wdata[15:0] x2; sw passes wdata.
- Load formatting: select byte by addr[1:0] or half by addr[1].
  - lb/lh sign-extend from bit 7/15.
  - lbu/lhu zero-extend.
  - lw passes the word.
- Illegal Load/Store code: no bus access, rdata=0, single-cycle DONE path (stall for one cycle only).
- Reset mid-BUSY: immediate return to IDLE, req dropped, and a late ack is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- With the macro: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=00, raises output misalign (1 bit, one-cycle pulse in the request cycle). No bus request is made, the FSM goes straight to DONE with rdata=0, and memory is untouched.
- Without the macro: the misalign port is absent, and the offending low address bits are ignored. Halves use addr[1] only; words use the aligned word.

Test Plan:
- sw addr=0x100 wdata=0xDEADBEEF, ack in first BUSY cycle -> dmem_we=1, be=1111, dmem_addr=0x100, stall high exactly 2 cycles.
- sb addr=0x103 wdata=0x000000A5 -> be=1000, dmem_wdata=0xA5A5A5A5.
- lb addr=0x202, dmem_rdata=0x12800000 -> rdata=0xFFFFFF80; same access as lbu -> rdata=0x00000080.
- lhu addr=0x302, dmem_rdata=0xBEEF1234 with 3 wait states -> rdata=0x0000BEEF, stall high 5 cycles.
- TIMEOUT_CYCLES=4, no ack -> bus_err pulse in 4th BUSY cycle, rdata=0, DONE, then IDLE; a later stray ack is ignored.
- reset asserted mid-BUSY, then released with ack high -> outputs at reset values, no DONE, FSM in IDLE. With MISALIGN_TRAP_EN: lw addr=0x101 -> misalign pulse, dmem_req never asserted.
